// File: rtl/prime_test_arbiter_if.sv
// Bundle of requester and is_prime unit signals shared by prime_test_arbiter.
// slave  : arbiter view (takes requests and unit status, drives grants and unit controls)
// master : environment view (requesters plus the is_prime unit)
interface prime_test_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_value;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    resp_valid;
    logic                  resp_result;
    logic                  pt_start;
    logic [31:0]           pt_value;
    logic                  pt_result;
    logic                  pt_done;

    modport slave (
        input  req_valid, req_value, pt_result, pt_done,
        output grant, resp_valid, resp_result, pt_start, pt_value
    );

    modport master (
        output req_valid, req_value, pt_result, pt_done,
        input  grant, resp_valid, resp_result, pt_start, pt_value
    );
endinterface

// File: rtl/prime_test_arbiter.sv
// Round-robin arbiter sharing one is_prime unit among NUM_REQ requesters.
// Optional watchdog: define PRIME_ARB_WATCHDOG_EN to abort a test after
// TIMEOUT_CYCLES cycles in RUN and raise a sticky error flag.
//
// state | meaning
// IDLE  | no owner; waiting for a request with the unit's done low
// RUN   | grant held, pt_start high, waiting for a rising pt_done
// DRAIN | response pulsed, grant cleared, waiting for pt_done to fall
module prime_test_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prime_test_arbiter_if.slave   bus,
    output logic                  busy,
    output logic                  error
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   cur_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [31:0]        pick_val;
    logic               done_q;
    logic               done_rise;
    logic               do_grant;
    logic               do_finish;
    logic               do_timeout;

    assign done_rise = bus.pt_done & ~done_q;
    assign busy      = (state != IDLE);

    // Round-robin search starting one past the last served requester.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_grant) + k) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_found && (j == cand) && bus.req_valid[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(j);
                end
            end
        end
    end

    // Candidate value of the selected requester.
    always_comb begin
        pick_val = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_idx == IDX_W'(j)) begin
                pick_val = bus.req_value[32*j +: 32];
            end
        end
    end

`ifdef PRIME_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Watchdog down-counter: loaded at grant, terminal count zero aborts the test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            if (do_grant) begin
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if ((state == RUN) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
            if (do_timeout) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES > 0);
    assign error      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_finish  = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                // A done still high from an aborted test must fall before a new grant.
                if (!bus.pt_done && pick_found) begin
                    do_grant  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (done_rise) begin
                    do_finish = 1'b1;
                    state_nxt = DRAIN;
                end
`ifdef PRIME_ARB_WATCHDOG_EN
                else if (wd_cnt == '0) begin
                    do_timeout = 1'b1;
                    state_nxt  = DRAIN;
                end
`endif
            end
            DRAIN: begin
                if (!bus.pt_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, unit control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q          <= 1'b0;
            bus.grant       <= '0;
            bus.resp_valid  <= '0;
            bus.resp_result <= 1'b0;
            bus.pt_start    <= 1'b0;
            bus.pt_value    <= '0;
            cur_idx         <= '0;
            last_grant      <= IDX_W'(NUM_REQ - 1);
        end else begin
            done_q         <= bus.pt_done;
            bus.resp_valid <= '0;
            if (do_grant) begin
                bus.grant    <= NUM_REQ'(1) << pick_idx;
                bus.pt_value <= pick_val;
                bus.pt_start <= 1'b1;
                cur_idx      <= pick_idx;
            end
            if (do_finish || do_timeout) begin
                // A timed-out test reports "not prime"; either way the owner moves to the back.
                bus.resp_valid  <= bus.grant;
                bus.resp_result <= do_finish ? bus.pt_result : 1'b0;
                bus.pt_start    <= 1'b0;
                bus.grant       <= '0;
                last_grant      <= cur_idx;
            end
        end
    end

endmodule

// File: doc/prime_test_arbiter.md
PRIME_TEST_ARBITER -- requirements
Module: prime_test_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, setting the number of requesters sharing one is_prime unit (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, setting the watchdog limit in clk cycles (used only with the watchdog).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  NUM_REQ  per-requester level request; the request is held until that requester's resp_valid.
REQ-006 The block SHALL have port req_value  input  32*NUM_REQ  flattened candidate values; requester i uses bits [32i+31:32i].
REQ-007 The block SHALL have port grant  output  NUM_REQ  one-hot owner of the is_prime unit; all zero when no requester owns it.
REQ-008 The block SHALL have port resp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port resp_result  output  1  primality result, valid while any resp_valid bit is high.
REQ-010 The block SHALL have port pt_start  output  1  level start to is_prime; held high until done rises.
REQ-011 The block SHALL have port pt_value  output  32  candidate value to is_prime; stable while pt_start is high.
REQ-012 The block SHALL have port pt_result  input  1  is_prime result, valid when pt_done rises.
REQ-013 The block SHALL have port pt_done  input  1  is_prime done level.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port error  output  1  sticky watchdog flag.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-017 In IDLE with pt_done=0 and any req_valid set, the block SHALL select the requester by round-robin search starting at (last_grant+1) mod NUM_REQ, then next cycle: enter RUN, set the grant bit, latch pt_value from that requester's slice, and assert pt_start.
REQ-018 In IDLE with pt_done=1 (stale done, e.g. after reset mid-test), the block SHALL NOT grant, and SHALL wait until pt_done=0.
REQ-019 In RUN, the block SHALL detect a rising pt_done (pt_done=1 with registered previous pt_done=0), and in the next cycle: pulse resp_valid[grant] for exactly one cycle, drive resp_result=pt_result (captured on the rising edge), deassert pt_start, update last_grant, enter DRAIN.
REQ-020 In DRAIN, grant SHALL drop to zero, and the block SHALL return to IDLE on the first cycle pt_done=0.
REQ-021 Request-to-pt_start latency SHALL be 1 cycle; the minimum spacing between pt_start deassert and the next pt_start assert SHALL be 2 cycles.
REQ-022 A req_valid deasserted while its requester is granted SHALL NOT abort the test; the resp_valid pulse SHALL still occur.
REQ-023 A requester re-asserting immediately after its response SHALL be served after every other pending requester (fairness; no starvation).
REQ-024 Value changes on req_value slices while a requester is granted SHALL NOT affect pt_value.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force: IDLE, grant=0, resp_valid=0, resp_result=0, pt_start=0, pt_value=0, busy=0, error=0, last_grant=NUM_REQ-1 (requester 0 first), prev pt_done=0, watchdog=0.
REQ-026 Reset mid-RUN SHALL discard the test with no resp_valid; REQ-018 protects against the unit's stale done.

Configuration
REQ-027 With macro PRIME_ARB_WATCHDOG_EN defined, the block SHALL count RUN cycles. On reaching TIMEOUT_CYCLES with no rising pt_done, it SHALL set error (sticky until reset), pulse resp_valid[grant] with resp_result=0, deassert pt_start, and enter DRAIN.
REQ-028 Without PRIME_ARB_WATCHDOG_EN, the block SHALL have no counter, SHALL wait in RUN indefinitely, and SHALL tie error to 0.

Verification
REQ-029 Single request: req_valid=4'b0001, value 7, model done after 10 cycles with result 1 -> pt_start 1 cycle after request, pt_value=7, resp_valid[0] one cycle with resp_result=1.
REQ-030 All four request at once (values 4,5,6,7) -> grants in order 0,1,2,3, results 0,1,0,1, exactly one resp_valid pulse each.
REQ-031 Fairness: requester 0 re-requests immediately after its response while requester 2 is pending -> requester 2 is granted before requester 0.
REQ-032 Reset during RUN with model done still high -> no resp_valid; after rst_n release, no grant until done=0, then normal service.
REQ-033 With the watchdog macro and TIMEOUT_CYCLES=16, model never asserts done -> after 16 RUN cycles, error=1, resp_valid pulse with resp_result=0, next request served normally with error still 1.
REQ-034 Requester drops req_valid mid-RUN and changes req_value -> pt_value unchanged and resp_valid still pulses.
